// File: rtl/nios_v1_send_data_pio.sv
// Avalon-MM PIO that queues bytes in a small FIFO and hands them to ReCOP
// over a valid/ack handshake, with a status/control register pair.
module nios_v1_send_data_pio #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ack
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    logic push_req, ctrl_wr, flush, clr_ovf;
    logic fifo_full, fifo_empty, push_ok, pop;
    logic [31:0] status, rd_mux;

    always_comb begin
        push_req   = chipselect & write & (address == 2'd0);
        ctrl_wr    = chipselect & write & (address == 2'd2);
        flush      = ctrl_wr & writedata[1];
        clr_ovf    = ctrl_wr & writedata[0];
        fifo_full  = (count == CNT_W'(DEPTH));
        fifo_empty = (count == '0);
        push_ok    = push_req & ~flush & ~fifo_full;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ack) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // flush overrides any load the handshake would otherwise perform
        if (flush) begin
            pop       = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_comb begin
        status              = '0;
        status[0]           = fifo_full;
        status[1]           = fifo_empty;
        status[2]           = out_valid;
        status[3]           = overflow;
        status[4 +: CNT_W]  = count;
        case (address)
            2'd0:    rd_mux = 32'(out_port);
            2'd1:    rd_mux = status;
            default: rd_mux = '0;
        endcase
    end

    assign out_valid = (state == PRESENT);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= writedata[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            out_port <= '0;
            readdata <= '0;
        end else begin
            state    <= state_nxt;
            readdata <= rd_mux;
            // a dropped push sets overflow even when a clear lands on the same edge
            if (push_req && !flush && fifo_full) overflow <= 1'b1;
            else if (clr_ovf)                    overflow <= 1'b0;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    out_port <= mem[rd_ptr];
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: doc/nios_v1_send_data_pio.md
NIOS_V1_SEND_DATA_PIO -- requirements
Module: nios_v1_send_data_pio

Interface
REQ-001 Parameter: DATA_W, default 8, width of out_port and of each queued entry.
REQ-002 Parameter: DEPTH, default 4, FIFO entries (power of 2, >=2); CNT_W = log2(DEPTH)+1.
REQ-003 Port: clk  input  1  sole clock; all logic rising-edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: address  input  2  Avalon-MM word address.
REQ-006 Port: chipselect  input  1  Avalon slave select.
REQ-007 Port: write  input  1  Avalon write strobe, qualified by chipselect.
REQ-008 Port: writedata  input  32  Avalon write data.
REQ-009 Port: readdata  output  32  registered Avalon read data.
REQ-010 Port: out_port  output  DATA_W  byte presented to ReCOP.
REQ-011 Port: out_valid  output  1  out_port holds an untransferred byte.
REQ-012 Port: out_ack  input  1  ReCOP accepts out_port this cycle.
REQ-013 One clock; reset is synchronous and active-high, ports named clk and reset.

Function
REQ-014 Register map: 0 DATA (W: push writedata[DATA_W-1:0]; R: out_port zero-extended), 1 STATUS (R only), 2 CONTROL (W only), 3 reserved (R 0, W ignored).
REQ-015 STATUS: bit0 full, bit1 empty, bit2 out_valid, bit3 overflow (sticky), bits[4+CNT_W-1:4] FIFO count; other bits 0.
REQ-016 CONTROL write: bit0=1 clears overflow; bit1=1 flush; other bits ignored.
REQ-017 readdata updates every cycle from address (no read strobe, no read side effects); 1-cycle latency.
REQ-018 Push = chipselect & write & address==0; accepted iff pre-cycle count < DEPTH.
REQ-019 Push with pre-cycle count == DEPTH: data dropped, overflow set next cycle, even if a pop occurs same cycle.
REQ-020 Simultaneous accepted push and pop: count unchanged, ordering preserved.
REQ-021 Pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-022 Output FSM states IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-023 IDLE & count>0: load FIFO head into out_port, pop, go PRESENT.
REQ-024 PRESENT & out_ack=0: hold out_port and out_valid stable.
REQ-025 PRESENT & out_ack=1 & count>0: load next head, pop, stay PRESENT (back-to-back, no bubble).
REQ-026 PRESENT & out_ack=1 & count==0: go IDLE; out_port retains last value.
REQ-027 out_ack while IDLE ignored.
REQ-028 Latency: push into empty FIFO, FSM IDLE at cycle N -> out_valid=1 with that byte at N+2.
REQ-029 Flush: FIFO count 0, pointers 0, FSM IDLE next cycle; flush beats push in same cycle (push discarded, no overflow); overflow unchanged unless bit0 also set.
REQ-030 Overflow clear and a same-cycle overflowing push: overflow ends set.

Reset
REQ-031 reset=1 at clock edge: readdata=0, out_port=0, out_valid=0, FSM IDLE, count=0, pointers=0, overflow=0.
REQ-032 reset has priority over all bus and out_ack activity; asserted mid-transfer discards queued and presented bytes.

Verification
REQ-033 After reset, write 0x5A to addr 0, out_ack=0 -> out_valid=1, out_port=0x5A at N+2, held until ack; ack one cycle -> out_valid=0 next cycle, STATUS reads empty=1.
REQ-034 Write 0x11,0x22,0x33 back-to-back, out_ack held 1 -> out_port 0x11,0x22,0x33 on consecutive cycles, out_valid continuous, then 0.
REQ-035 out_ack=0, write 6 bytes (DEPTH=4) -> 1 in output reg, 4 queued, 6th dropped; STATUS = full=1, overflow=1, count=4; CONTROL 0x1 -> overflow=0.
REQ-036 FIFO full, push and ack same cycle -> push dropped, overflow=1, count 4->3... then refilled correctly; sequence order intact.
REQ-037 Queue 3 bytes, out_valid=1, write CONTROL 0x2 -> next cycle out_valid=0, count=0; later write 0x77 delivered normally.
REQ-038 reset asserted while PRESENT with 2 queued -> all outputs 0, empty=1, no stale byte after reset released.
